// File: rtl/regression_arb.sv
`default_nettype none
// ============================================================================
// Module   : regression_arb
// Summary  : Two-requester arbiter fronting a shared combinational regression
//            datapath. Fixed-priority build: define REGR_FIXED_PRIO_EN.
// Revision : 1.0
// ============================================================================
module regression_arb #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               r0_valid,
    input  logic               r1_valid,
    output logic               r0_ready,
    output logic               r1_ready,
    input  logic [15:0]        r0_f0,
    input  logic [15:0]        r1_f0,
    input  logic [15:0]        r0_c1,
    input  logic [15:0]        r1_c1,
    input  logic [31:0]        r0_c0,
    input  logic [31:0]        r1_c0,
    input  logic               r0_cin,
    input  logic               r1_cin,
    output logic [15:0]        dp_f0,
    output logic [15:0]        dp_c1,
    output logic [31:0]        dp_c0,
    output logic               dp_cin,
    input  logic [31:0]        dp_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [31:0]        rsp_y,
    output logic               busy,
    output logic [COUNT_W-1:0] ops_done
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_calc = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    localparam logic [COUNT_W-1:0] c_one = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic               r_id;
    logic [15:0]        r_f0;
    logic [15:0]        r_c1;
    logic [31:0]        r_c0;
    logic               r_cin;
    logic [31:0]        r_y;
    logic [COUNT_W-1:0] r_ops;

    logic               w_idle;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_calc;

    // Grants are suppressed while reset is asserted so no ready leaks out.
    assign w_idle = (r_state == c_idle) && rst_n;

`ifdef REGR_FIXED_PRIO_EN
    assign w_gnt0 = w_idle & r0_valid;
    assign w_gnt1 = w_idle & r1_valid & ~r0_valid;
`else
    logic r_last;   // requester granted most recently; 1 so r0 wins the first tie

    assign w_gnt0 = w_idle & r0_valid & (~r1_valid | r_last);
    assign w_gnt1 = w_idle & r1_valid & (~r0_valid | ~r_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (w_gnt0 | w_gnt1) begin
            r_last <= w_gnt1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_id    <= 1'b0;
            r_f0    <= '0;
            r_c1    <= '0;
            r_c0    <= '0;
            r_cin   <= 1'b0;
            r_y     <= '0;
            r_ops   <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (w_gnt0 | w_gnt1) begin
                        r_id    <= w_gnt1;
                        r_f0    <= w_gnt1 ? r1_f0  : r0_f0;
                        r_c1    <= w_gnt1 ? r1_c1  : r0_c1;
                        r_c0    <= w_gnt1 ? r1_c0  : r0_c0;
                        r_cin   <= w_gnt1 ? r1_cin : r0_cin;
                        r_state <= c_calc;
                    end
                end
                c_calc: begin
                    r_y     <= dp_y;
                    r_state <= c_resp;
                end
                c_resp: begin
                    if (rsp_ready) begin
                        r_ops   <= r_ops + c_one;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Datapath inputs are only live during the compute cycle.
    assign w_calc    = (r_state == c_calc);
    assign dp_f0     = w_calc ? r_f0  : 16'd0;
    assign dp_c1     = w_calc ? r_c1  : 16'd0;
    assign dp_c0     = w_calc ? r_c0  : 32'd0;
    assign dp_cin    = w_calc ? r_cin : 1'b0;

    assign r0_ready  = w_gnt0;
    assign r1_ready  = w_gnt1;
    assign rsp_valid = (r_state == c_resp);
    assign rsp_id    = r_id;
    assign rsp_y     = r_y;
    assign busy      = (r_state != c_idle);
    assign ops_done  = r_ops;

endmodule
`default_nettype wire

// File: tb/tb_regression_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regression_arb
// Summary  : Self-checking bench for regression_arb against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_regression_arb;

    localparam int COUNT_W = 4;

    logic               clk;
    logic               rst_n;
    logic               r0_valid, r1_valid;
    logic               r0_ready, r1_ready;
    logic [15:0]        r0_f0, r1_f0, r0_c1, r1_c1;
    logic [31:0]        r0_c0, r1_c0;
    logic               r0_cin, r1_cin;
    logic [15:0]        dp_f0, dp_c1;
    logic [31:0]        dp_c0;
    logic               dp_cin;
    logic [31:0]        dp_y;
    logic               rsp_valid, rsp_ready, rsp_id;
    logic [31:0]        rsp_y;
    logic               busy;
    logic [COUNT_W-1:0] ops_done;

    regression_arb #(.COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_f0(r0_f0), .r1_f0(r1_f0), .r0_c1(r0_c1), .r1_c1(r1_c1),
        .r0_c0(r0_c0), .r1_c0(r1_c0), .r0_cin(r0_cin), .r1_cin(r1_cin),
        .dp_f0(dp_f0), .dp_c1(dp_c1), .dp_c0(dp_c0), .dp_cin(dp_cin),
        .dp_y(dp_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy), .ops_done(ops_done)
    );

    // Datapath stub: c0 + c1*f0 + cin, truncated to 32 bits.
    assign dp_y = dp_c0 + 32'(dp_c1) * 32'(dp_f0) + 32'(dp_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Transaction-level model: one pending job, cycles since its grant.
    bit          m_busy = 0;
    int          m_age  = 0;
    int          m_id   = 0;
    int          m_last = 1;
    int          m_ops  = 0;
    logic [31:0] m_y, m_c0;
    logic [15:0] m_f0, m_c1;
    logic        m_cin;
    int          grants[$];

    task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
`ifdef REGR_FIXED_PRIO_EN
        return r0_valid ? 0 : 1;
`else
        if (r0_valid && r1_valid) return (m_last == 1) ? 0 : 1;
        return r0_valid ? 0 : 1;
`endif
    endfunction

    // Check outputs mid-cycle, then advance the model across the rising edge.
    task automatic cycle();
        int g;
        longint y;
        @(negedge clk);
        g = -1;
        if (rst_n && !m_busy && (r0_valid || r1_valid)) g = pick();
        check_eq("r0_ready", r0_ready, g == 0);
        check_eq("r1_ready", r1_ready, g == 1);
        check_eq("busy", busy, m_busy);
        check_eq("rsp_valid", rsp_valid, m_busy && m_age >= 2);
        if (m_busy && m_age >= 2) begin
            check_eq("rsp_y", rsp_y, m_y);
            check_eq("rsp_id", rsp_id, m_id[0]);
        end
        if (m_busy && m_age == 1)
            check_eq("dp_ops", {dp_f0, dp_c1, dp_c0, dp_cin}, {m_f0, m_c1, m_c0, m_cin});
        else
            check_eq("dp_zero", {dp_f0, dp_c1, dp_c0, dp_cin}, 65'd0);
        check_eq("ops_done", ops_done, m_ops % (1 << COUNT_W));
        if (g >= 0) grants.push_back(g);
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_ops = 0;
        end else if (g >= 0) begin
            m_busy = 1; m_age = 1; m_id = g; m_last = g;
            m_f0  = g ? r1_f0  : r0_f0;
            m_c1  = g ? r1_c1  : r0_c1;
            m_c0  = g ? r1_c0  : r0_c0;
            m_cin = g ? r1_cin : r0_cin;
            y = longint'(m_c0) + longint'(m_c1) * longint'(m_f0) + longint'(m_cin);
            m_y = y[31:0];
        end else if (m_busy) begin
            if (m_age == 1) m_age = 2;
            else if (rsp_ready) begin
                m_busy = 0; m_ops++;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_busy; i++) cycle();
        check_eq("drain_idle", m_busy, 1'b0);
    endtask

    initial begin
        int nvalid;
        rst_n = 1'b0; r0_valid = 0; r1_valid = 0; rsp_ready = 0;
        r0_f0 = 0; r1_f0 = 0; r0_c1 = 0; r1_c1 = 0;
        r0_c0 = 0; r1_c0 = 0; r0_cin = 0; r1_cin = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
        check_eq("rst_rsp_y", rsp_y, 32'd0);
        check_eq("rst_rsp_id", rsp_id, 1'b0);
        check_eq("rst_ops", ops_done, 0);
        check_eq("rst_busy", busy, 1'b0);

        // Reset during compute abandons the job.
        r0_valid = 1; r0_f0 = 16'd7; r0_c1 = 16'd3; r0_c0 = 32'd1; rsp_ready = 1;
        cycle();
        r0_valid = 0; rst_n = 0;
        cycle();
        rst_n = 1;
        cycle();
        check_eq("mid_rst_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_ops", ops_done, 0);

        // Continuous tie: alternating grants (or always r0 in fixed build).
        grants.delete();
        r0_valid = 1; r1_valid = 1;
        r0_c0 = 32'd11; r1_c0 = 32'd22; r1_f0 = 16'd9; r1_c1 = 16'd4;
        repeat (12) cycle();
        r0_valid = 0; r1_valid = 0;
        drain();
        check_eq("tie_count", grants.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
`ifdef REGR_FIXED_PRIO_EN
            check_eq("tie_seq", grants[i], 0);
`else
            check_eq("tie_seq", grants[i], i % 2);
`endif
        end

        // Single r0 op with known result and latency.
        do_reset();
        r0_valid = 1; r0_f0 = 16'd5000; r0_c1 = 16'd100; r0_c0 = 32'd10000; r0_cin = 0;
        rsp_ready = 1;
        cycle();
        r0_valid = 0;
        cycle();
        check_eq("r25_valid", rsp_valid, 1'b1);
        check_eq("r25_y", rsp_y, 32'd510000);
        check_eq("r25_id", rsp_id, 1'b0);
        cycle();
        check_eq("r25_ops", ops_done, 1);

        // r1 at max operands with a five-cycle response stall.
        r1_valid = 1; r1_f0 = 16'hffff; r1_c1 = 16'hffff; r1_c0 = 0; r1_cin = 1;
        rsp_ready = 0;
        cycle();
        r1_valid = 0; r0_valid = 1;
        cycle();
        nvalid = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) nvalid++;
            check_eq("stall_y", rsp_y, 32'd4294836226);
            check_eq("stall_rdy", {r0_ready, r1_ready}, 2'b00);
            cycle();
        end
        check_eq("stall_cnt", nvalid, 5);
        r0_valid = 0; rsp_ready = 1;
        cycle();
        check_eq("stall_done", ops_done, 2);

        // r1 pulse while computing must not be granted.
        grants.delete();
        r0_valid = 1;
        cycle();
        r0_valid = 0; r1_valid = 1;
        cycle();
        r1_valid = 0;
        repeat (4) cycle();
        check_eq("pulse_grants", grants.size(), 1);

        // 17 back-to-back ops on a 4-bit counter wrap to 1.
        do_reset();
        r0_valid = 1; rsp_ready = 1;
        repeat (51) cycle();
        r0_valid = 0;
        check_eq("wrap_ops", ops_done, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r0_valid  = 1'($urandom_range(0, 1));
            r1_valid  = 1'($urandom_range(0, 1));
            r0_f0 = 16'($urandom); r1_f0 = 16'($urandom);
            r0_c1 = 16'($urandom); r1_c1 = 16'($urandom);
            r0_c0 = $urandom;      r1_c0 = $urandom;
            r0_cin = 1'($urandom); r1_cin = 1'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 63) != 0);
            cycle();
        end
        rst_n = 1; r0_valid = 0; r1_valid = 0; rsp_ready = 1;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regression_arb.md
REGRESSION_ARB -- requirements
Module: regression_arb

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports r0_valid/r1_valid  input  1 each  requester 0/1 operation pending.
REQ-005 SHALL have ports r0_ready/r1_ready  output  1 each  operands accepted this cycle.
REQ-006 SHALL have ports r0_f0/r1_f0  input  16, r0_c1/r1_c1  input  16, r0_c0/r1_c0  input  32, r0_cin/r1_cin  input  1  operands.
REQ-007 SHALL have ports dp_f0  output  16, dp_c1  output  16, dp_c0  output  32, dp_cin  output  1  drive to the shared combinational Regression datapath.
REQ-008 SHALL have port dp_y  input  32  datapath result.
REQ-009 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_y  output  32  result channel.
REQ-010 SHALL have ports busy  output  1 (state != IDLE) and ops_done  output  COUNT_W  completed-operation count.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, RESP.
REQ-012 In IDLE with any valid: grant one requester, assert its ready combinationally that cycle, register its operands and id, go CALC; no valid -> stay IDLE.
REQ-013 At most one ready SHALL be high per cycle; ready SHALL be low outside IDLE.
REQ-014 In CALC: dp_* driven from operand registers; dp_y registered into rsp_y; go RESP next cycle.
REQ-015 In IDLE and RESP, dp_* SHALL be driven to zero.
REQ-016 In RESP: rsp_valid=1, rsp_y/rsp_id stable; on rsp_ready=1 go IDLE, ops_done += 1 (wraps at 2^COUNT_W-1 -> 0).
REQ-017 Latency: accept at cycle t -> rsp_valid first high at t+2; minimum 3 cycles per operation.
REQ-018 rsp_ready held low SHALL stall indefinitely in RESP with outputs frozen; no new grant.
REQ-019 Round-robin: last-grant pointer updated at each grant; both valid -> grant the requester not granted last; single valid -> grant it regardless of pointer.
REQ-020 Requester dropping valid without ready SHALL cause no grant to it; operands SHALL only be sampled on the grant cycle.

Reset
REQ-021 On rst_n=0 at a clock edge: state=IDLE, r0_ready/r1_ready=0, rsp_valid=0, rsp_id=0, rsp_y=0, operand registers=0, ops_done=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-022 Reset mid-operation (CALC or RESP) SHALL abandon the transaction with no response and no ops_done increment.

Configuration
REQ-023 Macro REGR_FIXED_PRIO_EN defined: requester 0 SHALL always win when both valid; pointer unused.
REQ-024 Macro REGR_FIXED_PRIO_EN undefined: round-robin per REQ-019.

Verification (bench datapath stub: dp_y = dp_c0 + dp_c1*dp_f0 + dp_cin)
REQ-025 r0 only, f0=5000 c1=100 c0=10000 cin=0, rsp_ready=1 -> r0_ready at t, rsp_valid at t+2, rsp_y=510000, rsp_id=0, ops_done=1.
REQ-026 r0 and r1 both valid continuously, round-robin build -> grants alternate 0,1,0,1; REGR_FIXED_PRIO_EN build -> all grants to 0.
REQ-027 r1 f0=65535 c1=65535 c0=0 cin=1, rsp_ready low 5 cycles -> rsp_valid held 5 cycles, rsp_y=4294836226 stable, no ready asserted, completes on rsp_ready.
REQ-028 rst_n low during CALC of an r0 op -> next cycle IDLE, rsp_valid=0, ops_done unchanged, pointer=1.
REQ-029 COUNT_W=4, 17 back-to-back ops -> ops_done reads 1 after the 17th response.
REQ-030 r1 valid pulses one cycle while FSM in CALC -> no r1 grant, single response only.
